// File: rtl/mem_tx_sequencer.sv
// mem_tx_sequencer
// Runs host commands as bursts of 1..2^LEN_W beats. Each burst is one of:
//   memory write : sample DataIn, then write it to memory
//   memory read  : read memory, then transmit the word
//   direct       : sample DataIn, then transmit it
// The block also provides a configurable read latency, address auto-increment
// (wraps modulo 2^ADDR_W), a TxDone timeout and an abort on Active low.
// Completion is reported as a one-cycle Done pulse. Failures are reported as a
// one-cycle Error pulse plus a sticky ErrCode.
module mem_tx_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 2,
   parameter int RD_LAT     = 1,
   parameter int TX_TIMEOUT = 255
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Active,
   input  logic              CmdValid,
   output logic              CmdReady,
   input  logic              CmdMode,
   input  logic              CmdRW,
   input  logic [ADDR_W-1:0] CmdAddr,
   input  logic [LEN_W-1:0]  CmdLen,
   input  logic [DATA_W-1:0] DataIn,
   output logic              SampleData,
   output logic              MemEn,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   output logic              TxStart,
   output logic [DATA_W-1:0] TxData,
   input  logic              TxDone,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [1:0]        ErrCode
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SAMPLE   = 3'd1,
      ST_MEM_WR   = 3'd2,
      ST_MEM_RD   = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_TX_START = 3'd5,
      ST_TX_WAIT  = 3'd6
   } state_t;

   // The latency counter only needs to reach RD_LAT-1. The timeout counter
   // only needs to reach TX_TIMEOUT-1, because expiry is detected one count early.
   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = (TX_TIMEOUT > 0) ? TO_W'(TX_TIMEOUT - 1) : {TO_W{1'b0}};
   localparam logic             TO_EN    = (TX_TIMEOUT != 0);

   state_t            state_r;
   logic              mode_r;
   logic              rw_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  beat_r;
   logic [LAT_W-1:0]  lat_cnt_r;
   logic [TO_W-1:0]   to_cnt_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] tx_data_r;
   logic              done_r;
   logic              error_r;
   logic [1:0]        err_code_r;

   logic              last_beat_s;
   state_t            eob_state_s;

   // End-of-beat decision: finish the burst or return to the burst's first state
   always_comb begin
      last_beat_s = (beat_r == len_r);
      if (last_beat_s) begin
         eob_state_s = ST_IDLE;
      end else if (mode_r && rw_r) begin
         eob_state_s = ST_MEM_RD;
      end else begin
         eob_state_s = ST_SAMPLE;
      end
   end

   // Sequencer FSM with its datapath registers and registered status pulses
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         mode_r      <= 1'b0;
         rw_r        <= 1'b0;
         len_r       <= {LEN_W{1'b0}};
         beat_r      <= {LEN_W{1'b0}};
         lat_cnt_r   <= {LAT_W{1'b0}};
         to_cnt_r    <= {TO_W{1'b0}};
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         tx_data_r   <= {DATA_W{1'b0}};
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         err_code_r  <= 2'b00;
      end else begin
         done_r  <= 1'b0;
         error_r <= 1'b0;
         if ((state_r != ST_IDLE) && !Active) begin
            // Abort: drop straight to IDLE so no further strobes are issued
            state_r    <= ST_IDLE;
            error_r    <= 1'b1;
            err_code_r <= 2'b10;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (CmdValid && Active) begin
                     mode_r     <= CmdMode;
                     rw_r       <= CmdRW;
                     len_r      <= CmdLen;
                     beat_r     <= {LEN_W{1'b0}};
                     err_code_r <= 2'b00;
                     // The address register tracks base+beat for the whole burst
                     mem_addr_r <= CmdAddr;
                     state_r    <= (CmdMode && CmdRW) ? ST_MEM_RD : ST_SAMPLE;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_SAMPLE: begin
                  if (mode_r) begin
                     mem_wdata_r <= DataIn;
                     state_r     <= ST_MEM_WR;
                  end else begin
                     tx_data_r <= DataIn;
                     state_r   <= ST_TX_START;
                  end
               end
               ST_MEM_WR: begin
                  state_r <= eob_state_s;
                  done_r  <= last_beat_s;
                  if (!last_beat_s) begin
                     beat_r     <= beat_r + LEN_W'(1);
                     mem_addr_r <= mem_addr_r + ADDR_W'(1);
                  end else begin
                     beat_r <= beat_r;
                  end
               end
               ST_MEM_RD: begin
                  lat_cnt_r <= {LAT_W{1'b0}};
                  state_r   <= ST_RD_WAIT;
               end
               ST_RD_WAIT: begin
                  if (lat_cnt_r == LAT_LAST) begin
                     tx_data_r <= MemRData;
                     state_r   <= ST_TX_START;
                  end else begin
                     lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                  end
               end
               ST_TX_START: begin
                  to_cnt_r <= {TO_W{1'b0}};
                  state_r  <= ST_TX_WAIT;
               end
               ST_TX_WAIT: begin
                  // TxDone has priority over an expiring timeout in the same cycle
                  if (TxDone) begin
                     state_r <= eob_state_s;
                     done_r  <= last_beat_s;
                     if (!last_beat_s) begin
                        beat_r     <= beat_r + LEN_W'(1);
                        mem_addr_r <= mem_addr_r + ADDR_W'(1);
                     end else begin
                        beat_r <= beat_r;
                     end
                  end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                     state_r    <= ST_IDLE;
                     error_r    <= 1'b1;
                     err_code_r <= 2'b01;
                  end else if (TO_EN) begin
                     to_cnt_r <= to_cnt_r + TO_W'(1);
                  end else begin
                     to_cnt_r <= to_cnt_r;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign CmdReady   = (state_r == ST_IDLE) & Active & ~Reset;
   assign SampleData = (state_r == ST_SAMPLE);
   assign MemEn      = (state_r == ST_MEM_WR) | (state_r == ST_MEM_RD);
   assign MemWe      = (state_r == ST_MEM_WR);
   assign TxStart    = (state_r == ST_TX_START);
   assign Busy       = (state_r != ST_IDLE);
   assign MemAddr    = mem_addr_r;
   assign MemWData   = mem_wdata_r;
   assign TxData     = tx_data_r;
   assign Done       = done_r;
   assign Error      = error_r;
   assign ErrCode    = err_code_r;

endmodule

// File: tb/tb_mem_tx_sequencer.sv
// Directed bench for mem_tx_sequencer (RD_LAT=2, TX_TIMEOUT=4) with a
// behavioural synchronous memory of matching read latency.
module tb_mem_tx_sequencer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Active;
   logic       CmdValid;
   logic       CmdReady;
   logic       CmdMode;
   logic       CmdRW;
   logic [7:0] CmdAddr;
   logic [1:0] CmdLen;
   logic [7:0] DataIn;
   logic       SampleData;
   logic       MemEn;
   logic       MemWe;
   logic [7:0] MemAddr;
   logic [7:0] MemWData;
   logic [7:0] MemRData;
   logic       TxStart;
   logic [7:0] TxData;
   logic       TxDone;
   logic       Busy;
   logic       Done;
   logic       Error;
   logic [1:0] ErrCode;

   int n_checks = 0;
   int n_fails  = 0;
   int memen_cnt = 0;
   int memen_snap;

   logic [7:0] mem [0:255];
   logic [7:0] rd_p1;
   logic [7:0] rd_p2;

   mem_tx_sequencer #(
      .ADDR_W(8), .DATA_W(8), .LEN_W(2), .RD_LAT(2), .TX_TIMEOUT(4)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Active(Active),
      .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdMode(CmdMode), .CmdRW(CmdRW),
      .CmdAddr(CmdAddr), .CmdLen(CmdLen), .DataIn(DataIn), .SampleData(SampleData),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .TxStart(TxStart), .TxData(TxData), .TxDone(TxDone),
      .Busy(Busy), .Done(Done), .Error(Error), .ErrCode(ErrCode)
   );

   always #5 Clk = ~Clk;

   // Memory model: writes on MemEn&MemWe; read data appears two cycles after the read strobe
   always @(posedge Clk) begin
      if (MemEn && MemWe) mem[MemAddr] <= MemWData;
      if (MemEn && !MemWe) rd_p1 <= mem[MemAddr];
      rd_p2 <= rd_p1;
      if (MemEn === 1'b1) memen_cnt <= memen_cnt + 1;
   end
   assign MemRData = rd_p2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic rw, input logic [7:0] a, input logic [1:0] l);
      CmdMode  = m;
      CmdRW    = rw;
      CmdAddr  = a;
      CmdLen   = l;
      CmdValid = 1'b1;
      step();
      CmdValid = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Active = 1'b1; CmdValid = 1'b0; CmdMode = 1'b0; CmdRW = 1'b0;
      CmdAddr = 8'h00; CmdLen = 2'd0; DataIn = 8'h00; TxDone = 1'b0;

      // ---- reset state ----
      #2;
      check("rst_busy",     Busy,     1'b0);
      check("rst_ready",    CmdReady, 1'b0);
      check("rst_memen",    MemEn,    1'b0);
      check("rst_txstart",  TxStart,  1'b0);
      check("rst_done",     Done,     1'b0);
      check("rst_error",    Error,    1'b0);
      check("rst_errcode",  ErrCode,  2'b00);
      check("rst_memaddr",  MemAddr,  8'h00);
      check("rst_txdata",   TxData,   8'h00);
      step();
      Reset = 1'b0;
      #1;
      check("ready_after_rst", CmdReady, 1'b1);

      // ---- write burst at 0xFE, 3 beats, address wraps ----
      DataIn = 8'h11;
      issue(1'b1, 1'b0, 8'hFE, 2'd2);
      check("wr_c1_sample", SampleData, 1'b1);
      check("wr_c1_busy",   Busy,       1'b1);
      check("wr_c1_memen",  MemEn,      1'b0);
      step();
      check("wr_c2_memen",  MemEn,    1'b1);
      check("wr_c2_memwe",  MemWe,    1'b1);
      check("wr_c2_addr",   MemAddr,  8'hFE);
      check("wr_c2_wdata",  MemWData, 8'h11);
      DataIn = 8'h22;
      step();
      check("wr_c3_sample", SampleData, 1'b1);
      step();
      check("wr_c4_addr",   MemAddr,  8'hFF);
      check("wr_c4_wdata",  MemWData, 8'h22);
      DataIn = 8'h33;
      step();
      step();
      check("wr_c6_addr",   MemAddr,  8'h00);
      check("wr_c6_wdata",  MemWData, 8'h33);
      check("wr_c6_busy",   Busy,     1'b1);
      check("wr_c6_done",   Done,     1'b0);
      step();
      check("wr_c7_busy",   Busy,     1'b0);
      check("wr_c7_done",   Done,     1'b1);
      check("wr_c7_errcode", ErrCode, 2'b00);
      check("wr_mem_fe",    mem[8'hFE], 8'h11);
      check("wr_mem_ff",    mem[8'hFF], 8'h22);
      check("wr_mem_00",    mem[8'h00], 8'h33);
      step();
      check("wr_c8_done",   Done,     1'b0);
      check("wr_c8_addr_hold", MemAddr, 8'h00);

      // ---- preload 0x10=A5, 0x11=5A through the write path ----
      DataIn = 8'hA5;
      issue(1'b1, 1'b0, 8'h10, 2'd1);
      step();
      DataIn = 8'h5A;
      repeat (3) step();
      check("pre_done", Done, 1'b1);

      // ---- read burst at 0x10, 2 beats, RD_LAT=2 ----
      issue(1'b1, 1'b1, 8'h10, 2'd1);
      check("rd_c1_memen",  MemEn,      1'b1);
      check("rd_c1_memwe",  MemWe,      1'b0);
      check("rd_c1_addr",   MemAddr,    8'h10);
      check("rd_c1_sample", SampleData, 1'b0);
      step();
      check("rd_c2_memen",  MemEn,   1'b0);
      check("rd_c2_txstart", TxStart, 1'b0);
      step();
      check("rd_c3_txstart", TxStart, 1'b0);
      step();
      check("rd_c4_txstart", TxStart, 1'b1);
      check("rd_c4_txdata",  TxData,  8'hA5);
      step();
      check("rd_c5_txstart", TxStart, 1'b0);
      check("rd_c5_txdata",  TxData,  8'hA5);
      step();
      step();
      TxDone = 1'b1;
      step();
      TxDone = 1'b0;
      check("rd_c8_memen",  MemEn,   1'b1);
      check("rd_c8_addr",   MemAddr, 8'h11);
      check("rd_c8_done",   Done,    1'b0);
      repeat (3) step();
      check("rd_c11_txstart", TxStart, 1'b1);
      check("rd_c11_txdata",  TxData,  8'h5A);
      repeat (3) step();
      TxDone = 1'b1;
      step();
      TxDone = 1'b0;
      check("rd_done",      Done,    1'b1);
      check("rd_error",     Error,   1'b0);
      check("rd_errcode",   ErrCode, 2'b00);
      step();
      check("rd_done_pulse", Done,   1'b0);

      // ---- reset during RD_WAIT ----
      issue(1'b1, 1'b1, 8'h10, 2'd0);
      step();
      check("mrst_busy_before", Busy, 1'b1);
      Reset = 1'b1;
      #1;
      check("mrst_busy",    Busy,     1'b0);
      check("mrst_memen",   MemEn,    1'b0);
      check("mrst_txstart", TxStart,  1'b0);
      check("mrst_memaddr", MemAddr,  8'h00);
      check("mrst_txdata",  TxData,   8'h00);
      check("mrst_ready",   CmdReady, 1'b0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      #1;
      check("mrst_ready_after", CmdReady, 1'b1);
      check("mrst_busy_after",  Busy,     1'b0);

      // ---- direct transfer ----
      memen_snap = memen_cnt;
      DataIn = 8'h7E;
      issue(1'b0, 1'b0, 8'h00, 2'd0);
      check("dir_c1_sample", SampleData, 1'b1);
      check("dir_c1_memen",  MemEn,      1'b0);
      step();
      check("dir_c2_txstart", TxStart, 1'b1);
      check("dir_c2_txdata",  TxData,  8'h7E);
      step();
      check("dir_c3_txstart", TxStart, 1'b0);
      TxDone = 1'b1;
      step();
      TxDone = 1'b0;
      check("dir_done",       Done,      1'b1);
      check("dir_no_memen",   memen_cnt, memen_snap);

      // ---- timeout: TxDone never arrives ----
      DataIn = 8'h3C;
      issue(1'b0, 1'b0, 8'h00, 2'd0);
      step();
      check("to_txstart", TxStart, 1'b1);
      repeat (4) step();
      check("to_c6_busy",  Busy,  1'b1);
      check("to_c6_error", Error, 1'b0);
      step();
      check("to_error",    Error,   1'b1);
      check("to_errcode",  ErrCode, 2'b01);
      check("to_busy",     Busy,    1'b0);
      check("to_done",     Done,    1'b0);
      step();
      check("to_error_pulse",  Error,   1'b0);
      check("to_errcode_held", ErrCode, 2'b01);

      // ---- timeout: TxDone on the expiry cycle wins ----
      issue(1'b0, 1'b0, 8'h00, 2'd0);
      check("to2_errcode_clr", ErrCode, 2'b00);
      step();
      repeat (4) step();
      TxDone = 1'b1;
      step();
      TxDone = 1'b0;
      check("to2_done",    Done,    1'b1);
      check("to2_error",   Error,   1'b0);
      check("to2_errcode", ErrCode, 2'b00);

      // ---- abort during MEM_WR of beat 1 of a 4-beat write ----
      DataIn = 8'h55;
      issue(1'b1, 1'b0, 8'h40, 2'd3);
      step();
      check("ab_c2_addr", MemAddr, 8'h40);
      step();
      step();
      check("ab_c4_memwe", MemWe,   1'b1);
      check("ab_c4_addr",  MemAddr, 8'h41);
      Active = 1'b0;
      step();
      check("ab_error",   Error,   1'b1);
      check("ab_errcode", ErrCode, 2'b10);
      check("ab_busy",    Busy,    1'b0);
      check("ab_memen",   MemEn,   1'b0);
      check("ab_done",    Done,    1'b0);
      memen_snap = memen_cnt;
      repeat (3) step();
      check("ab_no_memen",     memen_cnt, memen_snap);
      check("ab_error_pulse",  Error,     1'b0);
      check("ab_errcode_held", ErrCode,   2'b10);
      check("ab_ready_low",    CmdReady,  1'b0);
      Active = 1'b1;
      #1;
      check("ab_ready_back",   CmdReady,  1'b1);
      DataIn = 8'h99;
      issue(1'b0, 1'b0, 8'h00, 2'd0);
      check("ab_errcode_clr",  ErrCode,    2'b00);
      check("ab_new_sample",   SampleData, 1'b1);
      step();
      check("ab_new_txdata",   TxData,     8'h99);
      step();
      TxDone = 1'b1;
      step();
      TxDone = 1'b0;
      check("ab_new_done",     Done,       1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
